pc_fetch_unit: RTL and testbench

Fetch stage sitting directly upstream of Instruction_Memory. Owns the program counter, drives the memory's PC input, and captures the returned instruction into a registered instruction/PC pair for decode. Supports a start gate for image preload, stall, taken-branch redirect with squash, and halt. Targets REG_BITS = 16 or 32, byte-addressed memory.

---
 rtl/pc_fetch_unit.sv | 116 +++++++++++
 tb/tb_pc_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and
// registers the returned instruction/PC pair for decode.
module pc_fetch_unit #(
  parameter int                  REG_BITS = 32,
  parameter logic [REG_BITS-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [REG_BITS-1:0] branch_target,
  input  logic [REG_BITS-1:0] instr_in,
  output logic [REG_BITS-1:0] pc_out,
  output logic [REG_BITS-1:0] instr_out,
  output logic [REG_BITS-1:0] instr_pc,
  output logic                instr_valid,
  output logic                misalign_err,
  output logic [15:0]         fetch_count,
  output logic [1:0]          state_out
);

  localparam int INSTR_BYTES = REG_BITS / 8;
  localparam int ALIGN       = (REG_BITS == 32) ? 2 : 1;
  localparam logic [REG_BITS-1:0] PC_STEP    = REG_BITS'(INSTR_BYTES);
  localparam logic [REG_BITS-1:0] ALIGN_MASK = {{(REG_BITS-ALIGN){1'b1}}, {ALIGN{1'b0}}};

  if (REG_BITS != 16 && REG_BITS != 32) begin : g_bad_width
    $error("pc_fetch_unit: REG_BITS must be 16 or 32");
  end

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [REG_BITS-1:0] pc_q, pc_d;
  logic [REG_BITS-1:0] instr_q, instr_d;
  logic [REG_BITS-1:0] ipc_q, ipc_d;
  logic                valid_q, valid_d;
  logic                mis_q, mis_d;
  logic [15:0]         count_q, count_d;

  // NOTE: every next-state value gets a hold default before the case, so no
  // path through this block can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = 1'b0;
    mis_d   = mis_q;
    count_d = count_q;

    unique case (state_q)
      BOOT: begin
        if (halt)       state_d = HALT;
        else if (start) state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (branch_taken) begin
          // Redirect squashes the wrong-path fetch; a simultaneous stall is overridden.
          pc_d = branch_target & ALIGN_MASK;
          if (|branch_target[ALIGN-1:0]) mis_d = 1'b1;
        end else if (stall) begin
          valid_d = valid_q;
        end else begin
          instr_d = instr_in;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_STEP;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from the
  // same pre-edge values; the reset is synchronous, sampled only on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      count_q <= count_d;
    end
  end

  assign pc_out       = pc_q;
  assign instr_out    = instr_q;
  assign instr_pc     = ipc_q;
  assign instr_valid  = valid_q;
  assign misalign_err = mis_q;
  assign fetch_count  = count_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: three instances (32-bit, 16-bit, 32-bit
// starting near the top of the address space) compared against a behavioural model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, halt, stall, branch_taken;
  logic [31:0] branch_target;

  logic [7:0] mem32 [256];
  logic [7:0] mem16 [256];

  logic [31:0] pc_a, io_a, ipc_a, in_a;
  logic [31:0] pc_c, io_c, ipc_c, in_c;
  logic [15:0] pc_b, io_b, ipc_b, in_b;
  logic        v_a, v_b, v_c, m_a, m_b, m_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [1:0]  st_a, st_b, st_c;

  assign in_a = {mem32[8'(pc_a + 32'd3)], mem32[8'(pc_a + 32'd2)], mem32[8'(pc_a + 32'd1)], mem32[pc_a[7:0]]};
  assign in_b = {mem16[8'(pc_b + 16'd1)], mem16[pc_b[7:0]]};
  assign in_c = {mem32[8'(pc_c + 32'd3)], mem32[8'(pc_c + 32'd2)], mem32[8'(pc_c + 32'd1)], mem32[pc_c[7:0]]};

  pc_fetch_unit #(.REG_BITS(32), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr_in(in_a),
    .pc_out(pc_a), .instr_out(io_a), .instr_pc(ipc_a), .instr_valid(v_a),
    .misalign_err(m_a), .fetch_count(cnt_a), .state_out(st_a));

  pc_fetch_unit #(.REG_BITS(16), .RESET_PC(16'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target[15:0]), .instr_in(in_b),
    .pc_out(pc_b), .instr_out(io_b), .instr_pc(ipc_b), .instr_valid(v_b),
    .misalign_err(m_b), .fetch_count(cnt_b), .state_out(st_b));

  pc_fetch_unit #(.REG_BITS(32), .RESET_PC(32'hFFFF_FFF0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr_in(in_c),
    .pc_out(pc_c), .instr_out(io_c), .instr_pc(ipc_c), .instr_valid(v_c),
    .misalign_err(m_c), .fetch_count(cnt_c), .state_out(st_c));

  typedef struct {
    int          st;
    logic [31:0] pc, io, ipc;
    logic        v, mis;
    int          cnt;
  } model_t;

  model_t      m [3];
  int          nbytes [3]  = '{4, 2, 4};
  logic [31:0] amask [3]   = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [31:0] rpc [3]     = '{32'h0, 32'h0, 32'hFFFF_FFF0};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(int i, logic [31:0] addr);
    logic [31:0] w = '0;
    for (int k = 0; k < nbytes[i]; k++)
      w[8*k +: 8] = (i == 1) ? mem16[8'(addr + 32'(k))] : mem32[8'(addr + 32'(k))];
    return w;
  endfunction

  // Model: 0 = waiting for start, 1 = fetching, 2 = halted.
  task automatic model_step(int i);
    if (!rst_n) begin
      m[i].st = 0; m[i].pc = rpc[i]; m[i].io = 0; m[i].ipc = 0;
      m[i].v = 0; m[i].mis = 0; m[i].cnt = 0;
    end else if (m[i].st == 0) begin
      if (halt)       m[i].st = 2;
      else if (start) m[i].st = 1;
    end else if (m[i].st == 1) begin
      if (halt) begin
        m[i].st = 2; m[i].v = 0;
      end else if (branch_taken) begin
        logic [31:0] t = branch_target & amask[i];
        m[i].pc = t - (t % nbytes[i]);
        if (t % nbytes[i] != 0) m[i].mis = 1;
        m[i].v = 0;
      end else if (!stall) begin
        m[i].io  = mem_word(i, m[i].pc);
        m[i].ipc = m[i].pc;
        m[i].v   = 1;
        m[i].pc  = (m[i].pc + nbytes[i]) & amask[i];
        if (m[i].cnt < 65535) m[i].cnt++;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] o_pc [3], o_io [3], o_ipc [3];
    logic        o_v [3], o_m [3];
    logic [15:0] o_cnt [3];
    logic [1:0]  o_st [3];
    o_pc  = '{pc_a, 32'(pc_b), pc_c};
    o_io  = '{io_a, 32'(io_b), io_c};
    o_ipc = '{ipc_a, 32'(ipc_b), ipc_c};
    o_v   = '{v_a, v_b, v_c};
    o_m   = '{m_a, m_b, m_c};
    o_cnt = '{cnt_a, cnt_b, cnt_c};
    o_st  = '{st_a, st_b, st_c};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d pc_out", i), o_pc[i], m[i].pc);
      check($sformatf("d%0d instr_out", i), o_io[i], m[i].io);
      check($sformatf("d%0d instr_pc", i), o_ipc[i], m[i].ipc);
      check($sformatf("d%0d instr_valid", i), 32'(o_v[i]), 32'(m[i].v));
      check($sformatf("d%0d misalign_err", i), 32'(o_m[i]), 32'(m[i].mis));
      check($sformatf("d%0d fetch_count", i), 32'(o_cnt[i]), 32'(m[i].cnt));
      check($sformatf("d%0d state", i), 32'(o_st[i]), 32'(m[i].st));
    end
  endtask

  // Inputs are driven at the falling edge; outputs are sampled at the next falling edge.
  task automatic step_cycle(bit cmp);
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    if (cmp) compare_all();
  endtask

  task automatic drive(bit r, bit s, bit h, bit st, bit b, logic [31:0] t);
    rst_n = r; start = s; halt = h; stall = st; branch_taken = b; branch_target = t;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem32[k] = 8'($urandom);
      mem16[k] = 8'($urandom);
    end
    for (int k = 0; k < 4; k++) mem32[k] = 8'hF0;
    for (int k = 4; k < 8; k++) mem32[k] = 8'h0F;
    mem16[0] = 8'hF0; mem16[1] = 8'hF0; mem16[2] = 8'h0F; mem16[3] = 8'h0F;

    // Reset, then start; the start edge itself captures nothing.
    drive(0, 0, 0, 0, 0, 0);
    step_cycle(1);
    check("reset pc_out", pc_a, 32'h0);
    check("reset wrap-instance pc_out", pc_c, 32'hFFFF_FFF0);
    drive(1, 1, 0, 0, 0, 0);
    step_cycle(1);
    check("start pc_out", pc_a, 32'h0);
    check("start instr_valid", 32'(v_a), 32'h0);
    step_cycle(1);
    check("first instr_out", io_a, 32'hF0F0_F0F0);
    check("first instr_pc", ipc_a, 32'h0);
    check("first fetch_count", 32'(cnt_a), 32'd1);
    check("16b first instr_out", 32'(io_b), 32'h0000_F0F0);
    check("16b pc_out step", 32'(pc_b), 32'h2);

    // Stall holds everything.
    drive(1, 0, 0, 1, 0, 0);
    repeat (3) step_cycle(1);
    check("stall pc_out", pc_a, 32'h4);
    check("stall instr_out", io_a, 32'hF0F0_F0F0);
    check("stall fetch_count", 32'(cnt_a), 32'd1);

    // Misaligned branch together with stall.
    drive(1, 0, 0, 1, 1, 32'h6);
    step_cycle(1);
    check("branch pc_out", pc_a, 32'h4);
    check("branch instr_valid", 32'(v_a), 32'h0);
    check("branch misalign_err", 32'(m_a), 32'h1);
    drive(1, 0, 0, 0, 0, 0);
    step_cycle(1);
    check("post-branch instr_out", io_a, 32'h0F0F_0F0F);
    check("post-branch instr_pc", ipc_a, 32'h4);

    // Halt beats a same-cycle branch; start cannot leave HALT.
    drive(1, 0, 1, 0, 1, 32'h40);
    step_cycle(1);
    check("halt state", 32'(st_a), 32'd2);
    check("halt pc_out", pc_a, 32'h8);
    check("halt instr_valid", 32'(v_a), 32'h0);
    drive(1, 1, 0, 0, 0, 0);
    repeat (3) step_cycle(1);
    check("halt sticky state", 32'(st_a), 32'd2);
    drive(0, 1, 0, 0, 0, 0);
    step_cycle(1);
    check("reset from halt state", 32'(st_a), 32'd0);
    check("reset from halt misalign", 32'(m_a), 32'h0);

    // Halt in BOOT beats start.
    drive(1, 1, 1, 0, 0, 0);
    step_cycle(1);
    check("boot halt state", 32'(st_a), 32'd2);

    // Randomized phase.
    drive(0, 0, 0, 0, 0, 0);
    step_cycle(1);
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), $urandom);
      step_cycle(1);
    end

    // Address wrap on the high-PC instance.
    drive(0, 0, 0, 0, 0, 0);
    step_cycle(1);
    drive(1, 1, 0, 0, 0, 0);
    step_cycle(1);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) step_cycle(1);
    check("wrap pc_out", pc_c, 32'h0);
    check("wrap last instr_pc", ipc_c, 32'hFFFF_FFFC);

    // Long uninterrupted run to reach fetch_count saturation.
    repeat (65540) step_cycle(0);
    compare_all();
    check("saturated fetch_count", 32'(cnt_a), 32'h0000_FFFF);
    step_cycle(1);
    check("saturation holds", 32'(cnt_b), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
